vga_timing_gen: RTL and testbench

- Parametrised VGA raster timing generator for the video controller; successor to the fixed 640x480 timing generator.
- Produces pixel/line counters for frame buffer addressing, plus sync, blanking and display-enable outputs.
- Sync, blank and display-enable outputs are delayed by a configurable pipeline depth to match frame-buffer/glyph fetch latency.
- Adds a line-doubling mode and a frame-based cursor blink timebase.
- Runs on the system clock, advanced by a pixel clock enable.

---
 rtl/vga_timing_gen.sv | 147 ++++++++++++++
 tb/tb_vga_timing_gen.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen - parametrised VGA raster timing generator.
//
// Keeps a horizontal/vertical raster position that advances on pix_en and
// derives sync, blanking and display-enable from it. Those five signals run
// through a PIPE-deep delay line so they line up with downstream fetch
// latency. Also produces undelayed line/frame start pulses and a
// frame-based cursor blink timebase.
//
// Ports:
//   clk          system clock
//   resetb       asynchronous active-low reset
//   pix_en       pixel clock enable; all state advances only when high
//   line_dbl     1 = y reports line/2 (double-scan), sampled combinationally
//   x            horizontal position (current counter value)
//   y            vertical position, or position/2 when line_dbl=1
//   hsync        horizontal sync at HSYNC_POL level, delayed PIPE ticks
//   vsync        vertical sync at VSYNC_POL level, delayed PIPE ticks
//   hblank       1 outside the horizontal active region, delayed PIPE ticks
//   vblank       1 outside the vertical active region, delayed PIPE ticks
//   de           display enable (~hblank & ~vblank), delayed PIPE ticks
//   line_start   one-clk pulse after h wraps to 0
//   frame_start  one-clk pulse after h and v both wrap to 0
//   blink        toggles every BLINK_FRAMES frames
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_FP         = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BP         = 48,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_FP         = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BP         = 33,
    parameter logic        HSYNC_POL    = 1'b0,
    parameter logic        VSYNC_POL    = 1'b0,
    parameter int unsigned PIPE         = 2,
    parameter int unsigned BLINK_FRAMES = 16,
    localparam int unsigned H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned XW          = $clog2(H_TOTAL),
    localparam int unsigned YW          = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          pix_en,
    input  logic          line_dbl,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          hsync,
    output logic          vsync,
    output logic          hblank,
    output logic          vblank,
    output logic          de,
    output logic          line_start,
    output logic          frame_start,
    output logic          blink
);

    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam int unsigned BW       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Delay-line word: {hsync, vsync, hblank, vblank, de}; idle = blanked.
    localparam logic [4:0] IDLE = {~HSYNC_POL, ~VSYNC_POL, 1'b1, 1'b1, 1'b0};

    logic [XW-1:0] h, h_next;
    logic [YW-1:0] v, v_next;
    logic          h_wrap, v_wrap;
    logic [BW-1:0] fcnt;
    logic          hsync_raw, vsync_raw, hblank_raw, vblank_raw;
    logic [4:0]    raw;
    logic [5*(PIPE+1)-1:0] pipe_q;

    // All range compares are done at 32 bits so boundaries equal to a
    // power-of-two total cannot wrap in the narrow counter width.
    always_comb begin
        h_wrap = (32'(h) == H_TOTAL - 1);
        v_wrap = (32'(v) == V_TOTAL - 1);
        h_next = h_wrap ? '0 : h + 1'b1;
        v_next = v;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : v + 1'b1;
        end
    end

    // Decode from the position being loaded, so stage 0 is aligned with x/y.
    always_comb begin
        hsync_raw  = ((32'(h_next) >= HS_START) && (32'(h_next) < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_raw  = ((32'(v_next) >= VS_START) && (32'(v_next) < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
        hblank_raw = (32'(h_next) >= H_ACTIVE);
        vblank_raw = (32'(v_next) >= V_ACTIVE);
        raw        = {hsync_raw, vsync_raw, hblank_raw, vblank_raw, ~hblank_raw & ~vblank_raw};
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            h           <= '0;
            v           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            fcnt        <= '0;
            blink       <= 1'b0;
        end else begin
            line_start  <= pix_en & h_wrap;
            frame_start <= pix_en & h_wrap & v_wrap;
            if (pix_en) begin
                h <= h_next;
                v <= v_next;
                if (h_wrap && v_wrap) begin
                    if (32'(fcnt) == BLINK_FRAMES - 1) begin
                        fcnt  <= '0;
                        blink <= ~blink;
                    end else begin
                        fcnt <= fcnt + 1'b1;
                    end
                end
            end
        end
    end

    generate
        if (PIPE == 0) begin : g_nopipe
            always_ff @(posedge clk or negedge resetb) begin
                if (!resetb) begin
                    pipe_q <= IDLE;
                end else if (pix_en) begin
                    pipe_q <= raw;
                end
            end
        end else begin : g_pipe
            always_ff @(posedge clk or negedge resetb) begin
                if (!resetb) begin
                    pipe_q <= {(PIPE+1){IDLE}};
                end else if (pix_en) begin
                    pipe_q <= {pipe_q[5*PIPE-1:0], raw};
                end
            end
        end
    endgenerate

    assign {hsync, vsync, hblank, vblank, de} = pipe_q[5*PIPE +: 5];

    assign x = h;
    assign y = line_dbl ? (v >> 1) : v;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

    localparam int unsigned HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int unsigned VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int unsigned HT = HA + HF + HS + HB;   // 16: power-of-two total
    localparam int unsigned VT = VA + VF + VS + VB;   // 10
    localparam int unsigned FT = HT * VT;
    localparam int unsigned PIPE = 3;
    localparam int unsigned BF = 2;
    localparam logic HPOL = 1'b1;
    localparam logic VPOL = 1'b0;
    localparam int unsigned XW = $clog2(HT);
    localparam int unsigned YW = $clog2(VT);

    logic clk = 1'b0;
    logic resetb, pix_en, line_dbl;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic hsync, vsync, hblank, vblank, de, line_start, frame_start, blink;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL),
        .PIPE(PIPE), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .resetb(resetb), .pix_en(pix_en), .line_dbl(line_dbl),
        .x(x), .y(y), .hsync(hsync), .vsync(vsync), .hblank(hblank),
        .vblank(vblank), .de(de), .line_start(line_start),
        .frame_start(frame_start), .blink(blink)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x, y, hsync, vsync, hblank, vblank, de, ls, fs, blink;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    bit stim_done = 1'b0;

    // Reference model: the raster is a pure function of the number of
    // pix_en ticks since reset.
    int t = 0;

    function automatic exp_t model(int tt, int ld, int ls, int fs);
        exp_t e;
        int p, hp, vp, v;
        v = (tt / HT) % VT;
        e.x = tt % HT;
        e.y = ld ? v / 2 : v;
        p = tt - int'(PIPE);
        if (p < 1) begin
            e.hsync = !HPOL; e.vsync = !VPOL; e.hblank = 1; e.vblank = 1; e.de = 0;
        end else begin
            hp = p % HT;
            vp = (p / HT) % VT;
            e.hsync  = (hp >= HA + HF && hp < HA + HF + HS) ? HPOL : !HPOL;
            e.vsync  = (vp >= VA + VF && vp < VA + VF + VS) ? VPOL : !VPOL;
            e.hblank = (hp >= HA);
            e.vblank = (vp >= VA);
            e.de     = (hp < HA) && (vp < VA);
        end
        e.ls = ls;
        e.fs = fs;
        e.blink = ((tt / FT) / BF) % 2;
        return e;
    endfunction

    always @(posedge clk) begin
        int ls, fs;
        ls = 0; fs = 0;
        if (!resetb) begin
            t = 0;
        end else if (pix_en) begin
            t = t + 1;
            ls = (t % HT == 0);
            fs = (t % FT == 0);
        end
        q.push_back(model(t, line_dbl, ls, fs));
    end

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // Monitor: the DUT presents a new output set every clock.
    initial begin
        exp_t e;
        while (!stim_done) begin
            @(posedge clk);
            #1;
            if (q.size() == 0) begin
                check("queue_empty", 0, 1);
            end else begin
                e = q.pop_front();
                check("x", int'(x), e.x);
                check("y", int'(y), e.y);
                check("hsync", int'(hsync), e.hsync);
                check("vsync", int'(vsync), e.vsync);
                check("hblank", int'(hblank), e.hblank);
                check("vblank", int'(vblank), e.vblank);
                check("de", int'(de), e.de);
                check("line_start", int'(line_start), e.ls);
                check("frame_start", int'(frame_start), e.fs);
                check("blink", int'(blink), e.blink);
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Stimulus: random pix_en duty, random line_dbl flips, a mid-frame reset.
    initial begin
        resetb = 1'b0;
        pix_en = 1'b0;
        line_dbl = 1'b0;
        repeat (3) @(negedge clk);
        resetb = 1'b1;
        // Full-rate phase.
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            pix_en = 1'b1;
            if ($urandom_range(0, 49) == 0) line_dbl = ~line_dbl;
        end
        // Random duty with occasional long gaps.
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0) begin
                pix_en = 1'b0;
                repeat ($urandom_range(5, 20)) @(negedge clk);
            end
            pix_en = ($urandom_range(0, 99) < 65);
            if ($urandom_range(0, 39) == 0) line_dbl = ~line_dbl;
        end
        // Mid-frame reset, held 3 clocks with pix_en active.
        pix_en = 1'b1;
        resetb = 1'b0;
        repeat (3) @(negedge clk);
        resetb = 1'b1;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            pix_en = ($urandom_range(0, 99) < 80);
            if ($urandom_range(0, 39) == 0) line_dbl = ~line_dbl;
        end
        @(negedge clk);
        stim_done = 1'b1;
    end

    // Hard time limit so the run always ends.
    initial begin
        #1000000;
        $display("FAIL timeout t=%0t actual=running expected=finished", $time);
        $fatal(1, "timeout");
    end

endmodule
